// File: rtl/backlight_led_tx_pkg.sv
// Shared types and helpers for the LED backlight transmitter: FSM encoding,
// timer sizing and the colour reordering the LED strip expects.
package backlight_led_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BIT,
      LATCH
   } txState_t;

   // One timer serves both the bit period and the latch gap, so it is sized for the longer.
   function automatic int timerWidth(input int tbit, input int trst);
      return $clog2((tbit > trst) ? tbit : trst);
   endfunction

   function automatic logic [23:0] packGrb(input logic [23:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

endpackage

// File: rtl/bl_pingpong_ram.sv
// Two-bank simple dual-port RAM: one bank fills with block colours while the
// other is read out by the transmitter. Read data is registered.
module bl_pingpong_ram #(
   parameter int DEPTH  = 144,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic              i_wrBank,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [23:0]       i_wrData,
   input  logic              i_rdBank,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [23:0]       o_rdData
);

   localparam int IDX_W = $clog2(2 * DEPTH);

   logic [23:0]      r_mem [2*DEPTH];
   logic [23:0]      r_rdData;
   logic [IDX_W-1:0] w_wrIdx;
   logic [IDX_W-1:0] w_rdIdx;

   assign w_wrIdx = i_wrBank ? IDX_W'(DEPTH) + IDX_W'(i_wrAddr) : IDX_W'(i_wrAddr);
   assign w_rdIdx = i_rdBank ? IDX_W'(DEPTH) + IDX_W'(i_rdAddr) : IDX_W'(i_rdAddr);

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[w_wrIdx] <= i_wrData;
      end
      r_rdData <= r_mem[w_rdIdx];
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/backlight_led_tx.sv
// Captures one frame of block-mean colours into a ping-pong buffer and, on each
// frame boundary, streams the finished bank to a WS2812-style LED strip.
module backlight_led_tx
   import backlight_led_tx_pkg::*;
#(
   parameter int BLK_H      = 16,
   parameter int BLK_V      = 9,
   parameter int SERPENTINE = 1,
   parameter int TBIT       = 185,
   parameter int T0H        = 59,
   parameter int T1H        = 119,
   parameter int TRST       = 44550
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_vs,
   input  logic [23:0] i_mean_color,
   input  logic        i_mean_valid,
   input  logic [5:0]  i_mean_row,
   output logic        o_led_dout,
   output logic        o_tx_busy,
   output logic        o_frame_done,
   output logic        o_frame_drop
);

   localparam int N      = BLK_H * BLK_V;
   localparam int ADDR_W = $clog2(N);
   localparam int TMR_W  = timerWidth(TBIT, TRST);
   localparam int COL_W  = $clog2(BLK_H + 1);

   logic              r_vsD, r_vsRise, r_wrBank, r_rdBank;
   logic [5:0]        r_lastRow;
   logic [COL_W-1:0]  r_col, w_col;
   logic              w_idle, w_swap, w_we, w_wrBankEff;
   logic [ADDR_W-1:0] w_wrAddr, w_rdAddr;
   logic [23:0]       w_rdData;

   txState_t          r_state, w_stateNxt;
   logic [TMR_W-1:0]  r_tmr, w_tmrNxt, w_highLen;
   logic [4:0]        r_bitIdx, w_bitIdxNxt;
   logic              r_loadPh, w_loadPhNxt;
   logic [5:0]        r_txRow, w_txRowNxt;
   logic [COL_W-1:0]  r_txCol, w_txColNxt, w_txColSel;
   logic [23:0]       r_shift, w_shiftNxt;
   logic              w_lastLed;

   assign w_idle      = (r_state == IDLE);
   assign w_swap      = r_vsRise & w_idle;
   assign w_col       = (r_vsRise || (i_mean_row != r_lastRow)) ? '0 : r_col;
   assign w_we        = i_mean_valid && (int'(w_col) < BLK_H) && (int'(i_mean_row) < BLK_V);
   assign w_wrAddr    = ADDR_W'(int'(i_mean_row) * BLK_H + int'(w_col));
   // A strobe landing on the swap cycle already belongs to the next frame.
   assign w_wrBankEff = w_swap ? ~r_wrBank : r_wrBank;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vsD     <= 1'b0;
         r_vsRise  <= 1'b0;
         r_wrBank  <= 1'b0;
         r_rdBank  <= 1'b0;
         r_col     <= '0;
         r_lastRow <= '0;
      end else begin
         r_vsD    <= i_vs;
         r_vsRise <= i_vs & ~r_vsD;
         if (w_swap) begin
            r_wrBank <= ~r_wrBank;
            r_rdBank <= r_wrBank;
         end
         if (i_mean_valid) begin
            r_lastRow <= i_mean_row;
            r_col     <= (int'(w_col) < BLK_H) ? w_col + 1'b1 : w_col;
         end else if (r_vsRise) begin
            r_col <= '0;
         end
      end
   end

   bl_pingpong_ram #(
      .DEPTH  (N),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk    (i_clk),
      .i_we     (w_we),
      .i_wrBank (w_wrBankEff),
      .i_wrAddr (w_wrAddr),
      .i_wrData (i_mean_color),
      .i_rdBank (r_rdBank),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData)
   );

   assign w_txColSel = (SERPENTINE == 1 && r_txRow[0]) ? COL_W'(BLK_H - 1) - r_txCol : r_txCol;
   assign w_rdAddr   = ADDR_W'(int'(r_txRow) * BLK_H + int'(w_txColSel));
   assign w_highLen  = r_shift[23] ? TMR_W'(T1H) : TMR_W'(T0H);
   assign w_lastLed  = (int'(r_txRow) == BLK_V - 1) && (int'(r_txCol) == BLK_H - 1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_tmr    <= '0;
         r_bitIdx <= '0;
         r_loadPh <= 1'b0;
         r_txRow  <= '0;
         r_txCol  <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_stateNxt;
         r_tmr    <= w_tmrNxt;
         r_bitIdx <= w_bitIdxNxt;
         r_loadPh <= w_loadPhNxt;
         r_txRow  <= w_txRowNxt;
         r_txCol  <= w_txColNxt;
         r_shift  <= w_shiftNxt;
      end
   end

   // LOAD spends one cycle presenting the address and one capturing the registered word.
   always_comb begin
      w_stateNxt  = r_state;
      w_tmrNxt    = r_tmr;
      w_bitIdxNxt = r_bitIdx;
      w_loadPhNxt = r_loadPh;
      w_txRowNxt  = r_txRow;
      w_txColNxt  = r_txCol;
      w_shiftNxt  = r_shift;
      case (r_state)
         IDLE: begin
            if (w_swap) begin
               w_stateNxt  = LOAD;
               w_loadPhNxt = 1'b0;
               w_txRowNxt  = '0;
               w_txColNxt  = '0;
            end
         end
         LOAD: begin
            if (!r_loadPh) begin
               w_loadPhNxt = 1'b1;
            end else begin
               w_loadPhNxt = 1'b0;
               w_shiftNxt  = packGrb(w_rdData);
               w_tmrNxt    = '0;
               w_bitIdxNxt = '0;
               w_stateNxt  = BIT;
            end
         end
         BIT: begin
            if (r_tmr == TMR_W'(TBIT - 1)) begin
               w_tmrNxt    = '0;
               w_shiftNxt  = {r_shift[22:0], 1'b0};
               w_bitIdxNxt = r_bitIdx + 5'd1;
               if (r_bitIdx == 5'd23) begin
                  if (w_lastLed) begin
                     w_stateNxt = LATCH;
                  end else begin
                     w_stateNxt = LOAD;
                     if (int'(r_txCol) == BLK_H - 1) begin
                        w_txColNxt = '0;
                        w_txRowNxt = r_txRow + 6'd1;
                     end else begin
                        w_txColNxt = r_txCol + 1'b1;
                     end
                  end
               end
            end else begin
               w_tmrNxt = r_tmr + 1'b1;
            end
         end
         LATCH: begin
            if (r_tmr == TMR_W'(TRST - 1)) begin
               w_stateNxt = IDLE;
               w_tmrNxt   = '0;
            end else begin
               w_tmrNxt = r_tmr + 1'b1;
            end
         end
         default: w_stateNxt = IDLE;
      endcase
   end

   assign o_led_dout   = (r_state == BIT) && (r_tmr < w_highLen);
   assign o_tx_busy    = !w_idle;
   assign o_frame_done = (r_state == LATCH) && (r_tmr == TMR_W'(TRST - 1));
   assign o_frame_drop = r_vsRise && !w_idle;

endmodule

// File: tb/tb_backlight_led_tx.sv
// Scoreboard bench for backlight_led_tx: decodes the LED bitstream back into
// GRB words and compares them against frames queued when each vs is driven.
module tb_backlight_led_tx;

   localparam int BH   = 4;
   localparam int BV   = 2;
   localparam int TB   = 10;
   localparam int T0   = 3;
   localparam int T1   = 7;
   localparam int TR   = 20;
   localparam int NLED = BH * BV;
   localparam int FLEN = NLED * (2 + 24 * TB) + TR;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vs = 1'b0;
   logic        meanValid = 1'b0;
   logic [23:0] meanColor = '0;
   logic [5:0]  meanRow = '0;
   logic        ledDout, txBusy, frameDone, frameDrop;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [23:0] expQ[$];
   logic [23:0] pend[NLED];
   int          cyc = 0;
   int          vsCyc = 0;

   backlight_led_tx #(
      .BLK_H(BH), .BLK_V(BV), .SERPENTINE(1), .TBIT(TB), .T0H(T0), .T1H(T1), .TRST(TR)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_vs         (vs),
      .i_mean_color (meanColor),
      .i_mean_valid (meanValid),
      .i_mean_row   (meanRow),
      .o_led_dout   (ledDout),
      .o_tx_busy    (txBusy),
      .o_frame_done (frameDone),
      .o_frame_drop (frameDrop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached before the test sequence ended");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] grb(input logic [23:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

   function automatic logic [23:0] colourOf(input int mode, input int k);
      logic [7:0] kb;
      kb = 8'(k);
      case (mode)
         0:       return {kb, 16'h0000};
         1:       return 24'h800001;
         default: return {8'(mode * 17) ^ kb, kb + 8'h5a, 8'(mode) - kb};
      endcase
   endfunction

   // Decoder state: bit/word assembly, shape bookkeeping and frame statistics.
   int          hiCnt = 0, bitCnt = 0, wordsRx = 0, bitInFrame = 0;
   int          busyLen = 0, doneCnt = 0, dropCnt = 0, badShape = 0;
   int          lastRise = 0, busyRiseCyc = 0, firstLedCyc = 0, per = 0, expPer = 0;
   int          firstHi[24];
   int          firstPer[24];
   logic [23:0] word = '0;
   logic        monBit, prevLed = 1'b0, prevBusy = 1'b0, prevDone = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         hiCnt = 0; bitCnt = 0; wordsRx = 0; bitInFrame = 0; busyLen = 0; badShape = 0;
         prevLed = 1'b0; prevBusy = 1'b0; prevDone = 1'b0;
      end else begin
         if (prevDone) checkOutput("busyAfterDone", 32'(txBusy), 32'd0);
         if (txBusy && !prevBusy) begin
            busyRiseCyc = cyc; busyLen = 0; wordsRx = 0; bitInFrame = 0;
            bitCnt = 0; hiCnt = 0; badShape = 0;
         end
         if (txBusy) busyLen++;
         if (frameDrop) dropCnt++;
         if (ledDout && !prevLed) begin
            if (bitInFrame == 0) begin
               firstLedCyc = cyc;
            end else begin
               per = cyc - lastRise;
               expPer = (bitCnt == 0) ? TB + 2 : TB;
               if (per != expPer) badShape++;
               if (wordsRx == 0) firstPer[bitCnt] = per;
            end
            lastRise = cyc;
            hiCnt = 0;
         end
         if (ledDout) begin
            hiCnt++;
         end else if (prevLed) begin
            monBit = (hiCnt >= (T0 + T1) / 2);
            word = {word[22:0], monBit};
            if (hiCnt != (monBit ? T1 : T0)) badShape++;
            if (wordsRx == 0) firstHi[bitCnt] = hiCnt;
            bitCnt++;
            bitInFrame++;
            if (bitCnt == 24) begin
               if (expQ.size() == 0) begin
                  checkOutput("expectedLedsQueued", 32'(expQ.size()), 32'd1);
               end else begin
                  checkOutput("ledWord", 32'(word), 32'(expQ.pop_front()));
               end
               checkOutput("bitShape", 32'(badShape), 32'd0);
               badShape = 0;
               bitCnt = 0;
               wordsRx++;
            end
         end
         if (frameDone) begin
            doneCnt++;
            checkOutput("frameLen", 32'(busyLen), 32'(FLEN));
            checkOutput("ledCount", 32'(wordsRx), 32'(NLED));
            checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
         end
         prevLed = ledDout;
         prevBusy = txBusy;
         prevDone = frameDone;
      end
   end

   // One mean_valid strobe; blk < 0 marks a strobe the DUT must ignore.
   task automatic applyStimulus(input logic [5:0] row, input logic [23:0] rgb, input int blk);
      @(posedge clk); #1;
      meanValid = 1'b1; meanRow = row; meanColor = rgb;
      if (blk >= 0) pend[blk] = rgb;
      @(posedge clk); #1;
      meanValid = 1'b0;
   endtask

   task automatic writeBlocks(input int mode, input int first);
      for (int k = first; k < NLED; k++) applyStimulus(6'(k / BH), colourOf(mode, k), k);
   endtask

   // Serpentine order: odd rows are read right-to-left.
   task automatic pushFrame();
      for (int i = 0; i < NLED; i++) begin
         int r, c;
         r = i / BH;
         c = i % BH;
         expQ.push_back(grb(pend[r * BH + ((r % 2 == 1) ? BH - 1 - c : c)]));
      end
   endtask

   task automatic startFrame(input bit accept, input bit strobe0, input logic [23:0] c0);
      @(posedge clk); #1;
      vs = 1'b1; vsCyc = cyc;
      if (accept) pushFrame();
      @(posedge clk); #1;
      if (strobe0) begin
         meanValid = 1'b1; meanRow = 6'd0; meanColor = c0; pend[0] = c0;
      end
      @(posedge clk); #1;
      meanValid = 1'b0; vs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic waitDone();
      for (int i = 0; i < 3 * FLEN; i++) begin
         @(negedge clk);
         if (frameDone) return;
      end
      checkOutput("doneTimeout", 32'(frameDone), 32'd1);
   endtask

   initial begin
      int d0, n0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstLed", 32'(ledDout), 32'd0);
      checkOutput("rstBusy", 32'(txBusy), 32'd0);
      checkOutput("rstDone", 32'(frameDone), 32'd0);
      checkOutput("rstDrop", 32'(frameDrop), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] single frame, serpentine order");
      n0 = doneCnt;
      writeBlocks(0, 0);
      startFrame(1, 0, 24'h0);
      waitDone();
      checkOutput("busyLatency", 32'(busyRiseCyc - vsCyc), 32'd2);
      checkOutput("ledLatency", 32'(firstLedCyc - vsCyc), 32'd4);
      repeat (3) @(negedge clk);
      checkOutput("doneOnce", 32'(doneCnt - n0), 32'd1);

      $display("[TB] bit shape");
      writeBlocks(1, 0);
      startFrame(1, 0, 24'h0);
      waitDone();
      checkOutput("oneBitHigh", 32'(firstHi[8]), 32'(T1));
      checkOutput("oneBitLow", 32'(firstPer[9] - firstHi[8]), 32'(TB - T1));
      checkOutput("zeroBitHigh", 32'(firstHi[0]), 32'(T0));
      checkOutput("zeroBitLow", 32'(firstPer[1] - firstHi[0]), 32'(TB - T0));

      $display("[TB] overrun");
      writeBlocks(2, 0);
      startFrame(1, 0, 24'h0);
      repeat (200) @(negedge clk);
      writeBlocks(3, 0);
      d0 = dropCnt;
      startFrame(0, 0, 24'h0);
      repeat (2) @(negedge clk);
      checkOutput("dropInBit", 32'(dropCnt - d0), 32'd1);
      writeBlocks(4, 0);
      for (int i = 0; i < 3 * FLEN && wordsRx < NLED; i++) @(negedge clk);
      checkOutput("allLedsBeforeLatch", 32'(wordsRx), 32'(NLED));
      repeat (8) @(negedge clk);
      d0 = dropCnt;
      startFrame(0, 0, 24'h0);
      checkOutput("dropInLatch", 32'(dropCnt - d0), 32'd1);
      waitDone();
      startFrame(1, 0, 24'h0);
      waitDone();

      $display("[TB] bounds");
      for (int k = NLED / 2; k < NLED; k++) applyStimulus(6'd1, colourOf(5, k), k);
      for (int k = 0; k < BH; k++) applyStimulus(6'd0, colourOf(5, k), k);
      applyStimulus(6'd0, 24'hdeadbe, -1);
      applyStimulus(6'd2, 24'hbadc0d, -1);
      startFrame(1, 0, 24'h0);
      waitDone();

      $display("[TB] reset during transmission");
      writeBlocks(6, 0);
      startFrame(1, 0, 24'h0);
      repeat (300) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      expQ.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midRstLed", 32'(ledDout), 32'd0);
      checkOutput("midRstBusy", 32'(txBusy), 32'd0);
      writeBlocks(7, 0);
      startFrame(1, 0, 24'h0);
      waitDone();

      $display("[TB] ping-pong");
      writeBlocks(8, 0);
      startFrame(1, 1, colourOf(9, 0));
      writeBlocks(9, 1);
      waitDone();
      startFrame(1, 0, 24'h0);
      waitDone();
      repeat (5) @(negedge clk);
      checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/backlight_led_tx.md
# backlight_led_tx

Consumes the per-block mean colour stream from the local-dimming block-mean stage and drives the LED backlight strip. One frame of block colours is captured into a ping-pong buffer. On each frame boundary the completed bank is serialised as a WS2812-style single-wire bitstream. The block sits between the block-mean pipeline and the LED driver pin, in the pixel clock domain.

## Interface
Parameters:
- BLK_H, 16: blocks per row.
- BLK_V, 9: block rows per frame.
- SERPENTINE, 1: when 1, odd rows are transmitted right-to-left.
- TBIT, 185: clocks per bit.
- T0H, 59: high clocks for a 0 bit.
- T1H, 119: high clocks for a 1 bit.
- TRST, 44550: low clocks for the latch gap.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- vs  in  1  vertical sync, active-high.
- mean_color  in  24  {R,G,B} block mean, 8 bits per channel.
- mean_valid  in  1  one-cycle strobe: mean_color is valid.
- mean_row  in  6  block row index of the current mean_color.
- led_dout  out  1  serial data to the LED strip.
- tx_busy  out  1  high from frame start through the end of the latch gap.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- frame_drop  out  1  one-cycle pulse when a frame swap is refused.

## Operation
- **Capture**
  - A column counter col counts mean_valid strobes.
  - col clears when mean_row differs from the row latched at the last strobe, and on a vs rising edge.
  - Write address = mean_row*BLK_H + col, into bank wr_bank.
  - A strobe is ignored if col ≥ BLK_H or mean_row ≥ BLK_V.
- **Swap**
  - A vs rising edge is detected with a 1-cycle registered vs.
  - If the transmitter is IDLE: wr_bank toggles, rd_bank takes the old wr_bank, and tx starts.
  - Otherwise frame_drop pulses and wr_bank is kept, so the next frame overwrites it.
- **Transmit FSM**
  - IDLE → LOAD on swap.
  - LOAD is 2 cycles: read address issued, then the registered RAM word is captured as G,R,B (GRB order). Then → BIT.
  - BIT: bits are sent MSB first, 24 per LED. led_dout = 1 for T0H or T1H clocks, then 0 until TBIT clocks have elapsed.
  - After bit 23: → LOAD for the next LED, or → LATCH after the last LED (BLK_H*BLK_V LEDs).
  - LATCH: led_dout = 0 for TRST clocks, frame_done pulses on the last cycle, → IDLE.
- **LED order**
  - Raster order by default.
  - With SERPENTINE=1, row r odd reads column BLK_H-1-c.
- **Width rules**
  - Address width is clog2(BLK_H*BLK_V).
  - Bit timer width is clog2(max(TBIT, TRST)).
  - Legal parameter ranges: T0H < T1H < TBIT, and all timing parameters ≥ 2.

## Timing
- **Reset values:** led_dout=0, tx_busy=0, frame_done=0, frame_drop=0; FSM in IDLE, wr_bank=0, col=0. Buffer contents are not cleared.
- **Start latency:** vs rises on cycle n; vs rise is detected at n+1; tx_busy=1 at n+2; the first led_dout high is at n+4.
- **Frame length:** N*(2 + 24*TBIT) + TRST clocks, with N = BLK_H*BLK_V.
- **Simultaneous events:**
  - A mean_valid strobe on the swap cycle is written to the new wr_bank.
  - A vs edge during LATCH is dropped.
- **Mid-operation reset:** rst during BIT returns led_dout to 0 on the next cycle and the FSM to IDLE. The LED strip sees at most a truncated bit, which is acceptable because the next frame is preceded by TRST.

## Structure
- Shared package holds:
  - the GRB packing function;
  - the bit-timer width constant;
  - the FSM state encoding (IDLE, LOAD, BIT, LATCH).
- One sub-module, bl_pingpong_ram: a dual-bank simple dual-port RAM of 24 bits × 2N.
  - Write port: bank bit plus address.
  - Read port: registered, 1-cycle latency.
- The capture logic and FSM stay in the top module.

## Test plan
Bench parameters: BLK_H=4, BLK_V=2, TBIT=10, T0H=3, T1H=7, TRST=20.

1. **Single frame:** write 8 blocks with colour = index (block k carries {8'hk,8'h0,8'h0}), then a vs edge → 8 LEDs decoded, with G=0, R=k, B=0. With SERPENTINE=1 the row-1 order is 7,6,5,4. frame_done pulses once, 8*242+20 clocks after tx_busy rises.
2. **Bit shape:** colour 24'h800001 → the first R bit is high for 7 clocks then low for 3. A 0 bit is high for 3 clocks and low for 7.
3. **Overrun:** a vs edge while tx_busy → frame_drop pulses for 1 cycle, tx continues unchanged, and the next frame is sent from the overwritten bank.
4. **Bounds:** 5 strobes in row 0, and a strobe with mean_row=2 → the 5th strobe and the row-2 strobe are ignored, with no corruption of blocks 4–7.
5. **Reset during BIT:** assert rst for 1 cycle → led_dout=0 and tx_busy=0 on the next cycle. A new vs edge then restarts cleanly from LED 0.
6. **Ping-pong:** frames A and B are sent back to back with a vs edge after each completes → the output alternates A, then B, with no mixing.
